dlx_step_sequencer: RTL and testbench

- Multi-cycle sequencer for the Extended DLX TinyML extensions.
- Issues a burst of `N` consecutive word-step requests, one per element, to a shared datapath resource such as a vector MAC or a memory port.
- Walks a 32-bit element address upward from a base, using a valid/ack handshake per step.
- Uses all-ones detection on the current address, gated by a pending-step condition, to trap address wrap-around before it happens.

---
 rtl/dlx_step_sequencer.sv | 117 +++++++++++
 tb/tb_dlx_step_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_step_sequencer.sv
// Burst step sequencer: issues `count` word-step requests from `base_addr` upward,
// one valid/ack handshake per element, trapping address wrap before it happens.
module dlx_step_sequencer #(
  parameter int AW  = 32,
  parameter int CW  = 16,
  parameter int GAP = 0
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] base_addr,
  input  logic [CW-1:0] count,
  input  logic          step_ack,
  output logic          step_valid,
  output logic [AW-1:0] step_addr,
  output logic          busy,
  output logic          done,
  output logic          wrap_err,
  output logic [2:0]    o_state
);

  // Handshake: a step transfers on a rising edge where step_valid and step_ack
  // are both high; step_valid/step_addr stay stable until then, and step_ack
  // while step_valid is low has no effect.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_GAPW  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [3:0] GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_rem;
  logic [3:0]    r_gap;
  logic          w_addr_max;
  logic          w_last;
  logic          w_advance;

  assign w_addr_max = &r_addr;
  assign w_last     = (r_rem == CW'(1));
  // A counted step: acked, not aborted, and neither the final step nor a wrap trap.
  assign w_advance  = step_ack && !abort && !w_last && !w_addr_max;

  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) w_next = (count == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        if (abort)             w_next = S_IDLE;
        else if (step_ack) begin
          if (w_last)          w_next = S_DONE;
          else if (w_addr_max) w_next = S_ERR;
          else if (GAP > 0)    w_next = S_GAPW;
          else                 w_next = S_ISSUE;
        end
      end
      S_GAPW: begin
        if (abort)                  w_next = S_IDLE;
        else if (r_gap == GAP_LAST) w_next = S_ISSUE;
      end
      S_DONE:  w_next = S_IDLE;
      S_ERR: begin
        if (abort) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr <= '0;
      r_rem  <= '0;
      r_gap  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start && !abort && count != '0) begin
            r_addr <= base_addr;
            r_rem  <= count;
          end
        end
        S_ISSUE: begin
          if (w_advance) begin
            r_addr <= r_addr + AW'(1);
            r_rem  <= r_rem - CW'(1);
            r_gap  <= '0;
          end
        end
        S_GAPW: begin
          if (!abort) r_gap <= r_gap + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign step_valid = (r_state == S_ISSUE);
  assign step_addr  = r_addr;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign wrap_err   = (r_state == S_ERR);
  assign o_state    = r_state;

endmodule

// File: tb/tb_dlx_step_sequencer.sv
// Bench for dlx_step_sequencer: GAP=0 and GAP=2 instances share stimulus and are
// checked every cycle against a burst-level model plus directed literal checks.
module tb_dlx_step_sequencer;

  logic        CLK;
  logic        RESET;
  logic        start;
  logic        abort;
  logic [31:0] base_addr;
  logic [15:0] count;
  logic        step_ack;

  logic        o_valid [2];
  logic [31:0] o_addr  [2];
  logic        o_busy  [2];
  logic        o_done  [2];
  logic        o_err   [2];
  logic [2:0]  o_st    [2];

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  dlx_step_sequencer #(.AW(32), .CW(16), .GAP(0)) u_g0 (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .step_ack(step_ack),
    .step_valid(o_valid[0]), .step_addr(o_addr[0]), .busy(o_busy[0]),
    .done(o_done[0]), .wrap_err(o_err[0]), .o_state(o_st[0])
  );

  dlx_step_sequencer #(.AW(32), .CW(16), .GAP(2)) u_g2 (
    .CLK(CLK), .RESET(RESET), .start(start), .abort(abort),
    .base_addr(base_addr), .count(count), .step_ack(step_ack),
    .step_valid(o_valid[1]), .step_addr(o_addr[1]), .busy(o_busy[1]),
    .done(o_done[1]), .wrap_err(o_err[1]), .o_state(o_st[1])
  );

  // ---------------- behavioural model ----------------
  // Burst view: active flag, next address, steps left, idle cycles still owed,
  // and the one-cycle completion / sticky error flags.
  int          gapv      [2] = '{0, 2};
  bit          m_init;
  bit          m_active  [2];
  bit          m_fin     [2];
  bit          m_err     [2];
  int          m_left    [2];
  int          m_owed    [2];
  logic [31:0] m_addr    [2];

  function automatic bit exp_valid(int k);
    return m_active[k] && !m_fin[k] && !m_err[k] && (m_owed[k] == 0);
  endfunction

  function automatic void model_step(int k);
    if (RESET) begin
      m_active[k] = 0; m_fin[k] = 0; m_err[k] = 0;
      m_left[k] = 0; m_owed[k] = 0; m_addr[k] = 32'h0;
    end else if (!m_active[k]) begin
      if (start && !abort) begin
        m_active[k] = 1;
        if (count == 16'd0) m_fin[k] = 1;
        else begin
          m_addr[k] = base_addr;
          m_left[k] = int'(count);
        end
      end
    end else if (abort) begin
      m_active[k] = 0; m_fin[k] = 0; m_err[k] = 0; m_owed[k] = 0;
    end else if (m_fin[k]) begin
      m_active[k] = 0; m_fin[k] = 0;
    end else if (m_err[k]) begin
      // sticky until abort
    end else if (m_owed[k] > 0) begin
      m_owed[k] = m_owed[k] - 1;
    end else if (step_ack) begin
      if (m_left[k] == 1)               m_fin[k] = 1;
      else if (m_addr[k] == 32'hFFFF_FFFF) m_err[k] = 1;
      else begin
        m_addr[k] = m_addr[k] + 32'd1;
        m_left[k] = m_left[k] - 1;
        m_owed[k] = gapv[k];
      end
    end
  endfunction

  always @(posedge CLK) begin
    if (RESET) m_init = 1;
    for (int k = 0; k < 2; k++) model_step(k);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_init) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("g%0d busy", k),     32'(o_busy[k]),  32'(m_active[k]));
        chk($sformatf("g%0d done", k),     32'(o_done[k]),  32'(m_fin[k]));
        chk($sformatf("g%0d wrap_err", k), 32'(o_err[k]),   32'(m_err[k]));
        chk($sformatf("g%0d valid", k),    32'(o_valid[k]), 32'(exp_valid(k)));
        if (exp_valid(k) || RESET)
          chk($sformatf("g%0d addr", k), o_addr[k], m_addr[k]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic set_in(input bit s, input bit a, input bit ack,
                        input logic [31:0] b, input logic [15:0] c);
    start = s; abort = a; step_ack = ack; base_addr = b; count = c;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((o_busy[0] || o_busy[1]) && n < budget) begin
      tick();
      n++;
    end
    chk("wait_idle timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_err_g2(input int budget);
    int n = 0;
    while (!o_err[1] && n < budget) begin
      tick();
      n++;
    end
    chk("wait_err timeout", 32'(n < budget), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET = 1'b1;
    set_in(1, 0, 1, 32'h55, 16'd5);

    // 1: reset dominates a held start
    repeat (4) begin
      tick();
      chk("rst busy",  32'(o_busy[0]),  32'd0);
      chk("rst valid", 32'(o_valid[0]), 32'd0);
      chk("rst addr",  o_addr[0],       32'd0);
    end
    RESET = 1'b0;
    tick();
    start = 0;
    chk("t1 first valid", 32'(o_valid[0]), 32'd1);
    chk("t1 first addr",  o_addr[0],       32'h55);
    wait_idle(200);

    // 2: four back-to-back steps on the GAP=0 instance
    tick();
    set_in(1, 0, 1, 32'h100, 16'd4);
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h100 + 32'(i));
    tick();
    start = 0;
    while (exp_q.size() > 0) begin
      chk("t2 valid", 32'(o_valid[0]), 32'd1);
      chk("t2 addr",  o_addr[0],       exp_q.pop_front());
      tick();
    end
    chk("t2 done", 32'(o_done[0]), 32'd1);
    chk("t2 busy in done", 32'(o_busy[0]), 32'd1);
    tick();
    chk("t2 done clears", 32'(o_done[0]), 32'd0);
    chk("t2 busy falls",  32'(o_busy[0]), 32'd0);
    wait_idle(200);

    // 3: wrap trap
    tick();
    set_in(1, 0, 1, 32'hFFFF_FFFE, 16'd3);
    tick();
    start = 0;
    chk("t3 step0", o_addr[0], 32'hFFFF_FFFE);
    tick();
    chk("t3 step1", o_addr[0], 32'hFFFF_FFFF);
    tick();
    chk("t3 err",      32'(o_err[0]),   32'd1);
    chk("t3 no step",  32'(o_valid[0]), 32'd0);
    start = 1;
    wait_err_g2(50);
    tick();
    start = 0;
    chk("t3 err held", 32'(o_err[0]), 32'd1);
    abort = 1;
    tick();
    abort = 0;
    chk("t3 err cleared", 32'(o_err[0]),  32'd0);
    chk("t3 idle",        32'(o_busy[1]), 32'd0);

    // 4: single step at the top address
    tick();
    set_in(1, 0, 1, 32'hFFFF_FFFF, 16'd1);
    tick();
    start = 0;
    chk("t4 addr", o_addr[0], 32'hFFFF_FFFF);
    tick();
    chk("t4 done", 32'(o_done[0]), 32'd1);
    chk("t4 no err", 32'(o_err[0]), 32'd0);
    wait_idle(200);

    // 5: zero-length burst
    tick();
    set_in(1, 0, 1, 32'h40, 16'd0);
    tick();
    start = 0;
    chk("t5 done", 32'(o_done[0]),  32'd1);
    chk("t5 busy", 32'(o_busy[0]),  32'd1);
    chk("t5 no valid", 32'(o_valid[0]), 32'd0);
    tick();
    chk("t5 busy falls", 32'(o_busy[0]), 32'd0);

    // 6: GAP=2 instance, delayed ack, abort on the second ack
    tick();
    set_in(1, 0, 1, 32'h200, 16'd3);
    tick();
    start = 0;
    chk("t6 step0", o_addr[1], 32'h200);
    tick();
    chk("t6 gap a", 32'(o_valid[1]), 32'd0);
    tick();
    chk("t6 gap b", 32'(o_valid[1]), 32'd0);
    tick();
    chk("t6 step1 valid", 32'(o_valid[1]), 32'd1);
    chk("t6 step1 addr",  o_addr[1],       32'h201);
    step_ack = 0;
    repeat (3) begin
      tick();
      chk("t6 held valid", 32'(o_valid[1]), 32'd1);
      chk("t6 held addr",  o_addr[1],       32'h201);
    end
    step_ack = 1;
    abort = 1;
    tick();
    abort = 0;
    step_ack = 0;
    chk("t6 aborted", 32'(o_busy[1]), 32'd0);
    chk("t6 no done", 32'(o_done[1]), 32'd0);
    wait_idle(200);

    // randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      tick();
      step_ack = ($urandom_range(0, 9) < 7);
      abort    = ($urandom_range(0, 99) < 3);
      RESET    = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 9) == 0);
      count    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20))
                                             : 16'($urandom_range(0, 6));
      base_addr = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 8)))
                                              : $urandom;
    end
    tick();
    set_in(0, 1, 0, 32'h0, 16'd0);
    RESET = 0;
    tick();
    abort = 0;
    wait_idle(200);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
